hazard_ctrl: RTL and testbench

- Pipeline sequencing controller for the 5-stage RV32 core.
- Consumes the ID-stage 8-bit control word and register fields, the EX branch resolution and the data-memory ready handshake.
- Drives stage enables, flushes and bubbles: load-use stall, taken-branch flush, memory wait-state freeze, and a sticky memory-timeout error.
- Keeps its own shadow copies of the EX/MEM hazard state.

---
 rtl/hazard_ctrl.sv | 197 +++++++++++++++++++
 tb/tb_hazard_ctrl.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller for the 5-stage RV32 core: load-use stall,
// taken-branch flush, data-memory wait-state freeze and sticky timeout error.
module hazard_ctrl #(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             id_valid,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic [4:0]       id_rd,
  input  logic [7:0]       id_ctl,
  input  logic             ex_branch_taken,
  input  logic             mem_ready,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic             exmem_en,
  output logic             memwb_bubble,
  output logic             mem_err,
  output logic [CNT_W-1:0] lu_stall_cnt,
  output logic [CNT_W-1:0] mem_wait_cnt
);

  localparam int WC_W = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);
  localparam logic [WC_W-1:0] WC_LIMIT = WC_W'(MEM_TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_ERR      = 2'd2
  } state_t;

  state_t            state_r;
  logic [WC_W-1:0]   wait_ctr_r;
  logic [4:0]        ex_rd_r;
  logic              ex_memread_r;
  logic              ex_memwrite_r;
  logic              mem_acc_r;
  logic [CNT_W-1:0]  lu_stall_cnt_r;
  logic [CNT_W-1:0]  mem_wait_cnt_r;

  logic              hazard_s;
  logic              freeze_req_s;
  logic              pc_en_s;
  logic              ifid_en_s;
  logic              ifid_flush_s;
  logic              idex_bubble_s;
  logic              exmem_en_s;
  logic              memwb_bubble_s;
  logic              lu_stall_s;
  logic              mem_freeze_s;

  // rs2 only matters when the instruction actually reads it: R-type/branch (ALUSrc=0) or a store.
  assign hazard_s = id_valid & ex_memread_r & (ex_rd_r != 5'd0) &
                    ((id_rs1 == ex_rd_r) |
                     ((id_rs2 == ex_rd_r) & (~id_ctl[7] | id_ctl[3])));

  // In MEM_WAIT the outstanding access is by definition still pending.
  assign freeze_req_s = ~mem_ready & (mem_acc_r | (state_r == ST_MEM_WAIT));

  // Stage enable / bubble decode from FSM state and current-cycle inputs.
  always_comb begin
    pc_en_s        = 1'b1;
    ifid_en_s      = 1'b1;
    ifid_flush_s   = 1'b0;
    idex_bubble_s  = 1'b0;
    exmem_en_s     = 1'b1;
    memwb_bubble_s = 1'b0;
    lu_stall_s     = 1'b0;
    mem_freeze_s   = 1'b0;
    if (!reset_n) begin
      pc_en_s   = 1'b1;
      ifid_en_s = 1'b1;
    end else begin
      case (state_r)
        ST_RUN, ST_MEM_WAIT: begin
          if (freeze_req_s) begin
            pc_en_s        = 1'b0;
            ifid_en_s      = 1'b0;
            exmem_en_s     = 1'b0;
            memwb_bubble_s = 1'b1;
            mem_freeze_s   = 1'b1;
          end else if (ex_branch_taken) begin
            ifid_flush_s  = 1'b1;
            idex_bubble_s = 1'b1;
          end else if (hazard_s) begin
            pc_en_s       = 1'b0;
            ifid_en_s     = 1'b0;
            idex_bubble_s = 1'b1;
            lu_stall_s    = 1'b1;
          end else begin
            pc_en_s = 1'b1;
          end
        end
        ST_ERR: begin
          pc_en_s        = 1'b0;
          ifid_en_s      = 1'b0;
          exmem_en_s     = 1'b0;
          memwb_bubble_s = 1'b1;
        end
        default: begin
          pc_en_s        = 1'b0;
          ifid_en_s      = 1'b0;
          exmem_en_s     = 1'b0;
          memwb_bubble_s = 1'b1;
        end
      endcase
    end
  end

  // FSM and memory wait counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r    <= ST_RUN;
      wait_ctr_r <= {WC_W{1'b0}};
    end else begin
      case (state_r)
        ST_RUN: begin
          if (freeze_req_s) begin
            state_r    <= ST_MEM_WAIT;
            wait_ctr_r <= {{(WC_W-1){1'b0}}, 1'b1};
          end else begin
            state_r <= ST_RUN;
          end
        end
        ST_MEM_WAIT: begin
          if (mem_ready) begin
            state_r    <= ST_RUN;
            wait_ctr_r <= {WC_W{1'b0}};
          end else if (wait_ctr_r >= WC_LIMIT) begin
            state_r <= ST_ERR;
          end else begin
            wait_ctr_r <= wait_ctr_r + {{(WC_W-1){1'b0}}, 1'b1};
          end
        end
        ST_ERR: begin
          state_r <= ST_ERR;
        end
        default: begin
          state_r <= ST_ERR;
        end
      endcase
    end
  end

  // Shadow copies of the EX/MEM hazard state; they move only when the pipe advances.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ex_rd_r       <= 5'd0;
      ex_memread_r  <= 1'b0;
      ex_memwrite_r <= 1'b0;
      mem_acc_r     <= 1'b0;
    end else if (exmem_en_s) begin
      ex_rd_r       <= id_rd;
      ex_memread_r  <= id_ctl[4] & id_valid & ~idex_bubble_s;
      ex_memwrite_r <= id_ctl[3] & id_valid & ~idex_bubble_s;
      mem_acc_r     <= ex_memread_r | ex_memwrite_r;
    end else begin
      mem_acc_r <= mem_acc_r;
    end
  end

  // Saturating performance counters.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lu_stall_cnt_r <= {CNT_W{1'b0}};
      mem_wait_cnt_r <= {CNT_W{1'b0}};
    end else begin
      if (lu_stall_s && (lu_stall_cnt_r != CNT_MAX)) begin
        lu_stall_cnt_r <= lu_stall_cnt_r + CNT_ONE;
      end else begin
        lu_stall_cnt_r <= lu_stall_cnt_r;
      end
      if (mem_freeze_s && (mem_wait_cnt_r != CNT_MAX)) begin
        mem_wait_cnt_r <= mem_wait_cnt_r + CNT_ONE;
      end else begin
        mem_wait_cnt_r <= mem_wait_cnt_r;
      end
    end
  end

  assign pc_en        = pc_en_s;
  assign ifid_en      = ifid_en_s;
  assign ifid_flush   = ifid_flush_s;
  assign idex_bubble  = idex_bubble_s;
  assign exmem_en     = exmem_en_s;
  assign memwb_bubble = memwb_bubble_s;
  assign mem_err      = (state_r == ST_ERR);
  assign lu_stall_cnt = lu_stall_cnt_r;
  assign mem_wait_cnt = mem_wait_cnt_r;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl: load-use, branch priority,
// memory wait freeze, timeout error and reset recovery.
module tb_hazard_ctrl;

  localparam int CNT_W = 16;

  localparam logic [7:0] LW   = 8'b11110000;
  localparam logic [7:0] ADD  = 8'b00100010;
  localparam logic [7:0] ADDI = 8'b10100011;
  localparam logic [7:0] SW   = 8'b10001000;

  // {pc_en, ifid_en, ifid_flush, idex_bubble, exmem_en, memwb_bubble}
  localparam logic [5:0] NORM   = 6'b110010;
  localparam logic [5:0] STALL  = 6'b000110;
  localparam logic [5:0] FLUSH  = 6'b111110;
  localparam logic [5:0] FREEZE = 6'b000001;

  logic             clk;
  logic             reset_n;
  logic             id_valid;
  logic [4:0]       id_rs1;
  logic [4:0]       id_rs2;
  logic [4:0]       id_rd;
  logic [7:0]       id_ctl;
  logic             ex_branch_taken;
  logic             mem_ready;
  logic             pc_en;
  logic             ifid_en;
  logic             ifid_flush;
  logic             idex_bubble;
  logic             exmem_en;
  logic             memwb_bubble;
  logic             mem_err;
  logic [CNT_W-1:0] lu_stall_cnt;
  logic [CNT_W-1:0] mem_wait_cnt;

  int n_asserts = 0;
  int n_fail    = 0;

  hazard_ctrl #(.MEM_TIMEOUT(15), .CNT_W(CNT_W)) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .id_valid        (id_valid),
    .id_rs1          (id_rs1),
    .id_rs2          (id_rs2),
    .id_rd           (id_rd),
    .id_ctl          (id_ctl),
    .ex_branch_taken (ex_branch_taken),
    .mem_ready       (mem_ready),
    .pc_en           (pc_en),
    .ifid_en         (ifid_en),
    .ifid_flush      (ifid_flush),
    .idex_bubble     (idex_bubble),
    .exmem_en        (exmem_en),
    .memwb_bubble    (memwb_bubble),
    .mem_err         (mem_err),
    .lu_stall_cnt    (lu_stall_cnt),
    .mem_wait_cnt    (mem_wait_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_asserts++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic chk_ctl(input string tag, input logic [5:0] exp);
    chk(tag, {26'd0, pc_en, ifid_en, ifid_flush, idex_bubble, exmem_en, memwb_bubble},
        {26'd0, exp});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [4:0] rd, input logic [7:0] ctl);
    id_valid = v;
    id_rs1   = rs1;
    id_rs2   = rs2;
    id_rd    = rd;
    id_ctl   = ctl;
  endtask

  initial begin
    reset_n         = 1'b0;
    ex_branch_taken = 1'b1;
    mem_ready       = 1'b1;
    set_id(1'b0, 5'd0, 5'd0, 5'd0, 8'd0);
    #3;
    chk_ctl("rst_ctl", NORM);
    chk("rst_lu", 32'(lu_stall_cnt), 32'd0);
    chk("rst_mw", 32'(mem_wait_cnt), 32'd0);
    chk("rst_err", 32'(mem_err), 32'd0);
    ex_branch_taken = 1'b0;
    #4 reset_n = 1'b1;

    // 1: basic load-use
    set_id(1'b1, 5'd0, 5'd0, 5'd5, LW);
    #1 chk_ctl("t1_lw", NORM);
    tick();
    set_id(1'b1, 5'd5, 5'd6, 5'd7, ADD);
    #1 chk_ctl("t1_stall", STALL);
    tick();
    chk("t1_cnt", 32'(lu_stall_cnt), 32'd1);
    #1 chk_ctl("t1_release", NORM);
    tick();

    // 2: addi rs2 field ignored, store data reg, load to x0
    set_id(1'b1, 5'd0, 5'd0, 5'd5, LW);
    tick();
    set_id(1'b1, 5'd3, 5'd5, 5'd8, ADDI);
    #1 chk_ctl("t2_addi", NORM);
    tick();
    set_id(1'b1, 5'd0, 5'd0, 5'd5, LW);
    tick();
    set_id(1'b1, 5'd3, 5'd5, 5'd0, SW);
    #1 chk_ctl("t2_sw", STALL);
    tick();
    chk("t2_sw_cnt", 32'(lu_stall_cnt), 32'd2);
    set_id(1'b1, 5'd0, 5'd0, 5'd0, LW);
    tick();
    set_id(1'b1, 5'd0, 5'd0, 5'd9, ADD);
    #1 chk_ctl("t2_x0", NORM);
    tick();
    chk("t2_x0_cnt", 32'(lu_stall_cnt), 32'd2);

    // 3: branch beats load-use
    set_id(1'b1, 5'd0, 5'd0, 5'd5, LW);
    tick();
    set_id(1'b1, 5'd5, 5'd6, 5'd7, ADD);
    ex_branch_taken = 1'b1;
    #1 chk_ctl("t3_flush", FLUSH);
    tick();
    ex_branch_taken = 1'b0;
    chk("t3_cnt", 32'(lu_stall_cnt), 32'd2);

    // 4: three wait cycles then release
    set_id(1'b1, 5'd0, 5'd0, 5'd9, LW);
    tick();
    set_id(1'b0, 5'd0, 5'd0, 5'd0, 8'd0);
    tick();
    mem_ready = 1'b0;
    #1 chk_ctl("t4_w1", FREEZE);
    tick();
    ex_branch_taken = 1'b1;
    #1 chk_ctl("t4_w2_branch_ignored", FREEZE);
    tick();
    ex_branch_taken = 1'b0;
    #1 chk_ctl("t4_w3", FREEZE);
    tick();
    mem_ready = 1'b1;
    #1 chk_ctl("t4_release", NORM);
    tick();
    chk("t4_mw_cnt", 32'(mem_wait_cnt), 32'd3);
    mem_ready = 1'b0;
    #1 chk_ctl("t4_no_access", NORM);
    tick();
    mem_ready = 1'b1;

    // 5: timeout into ERR
    set_id(1'b1, 5'd0, 5'd0, 5'd9, LW);
    tick();
    set_id(1'b0, 5'd0, 5'd0, 5'd0, 8'd0);
    tick();
    mem_ready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      #1 chk_ctl("t5_wait", FREEZE);
      chk("t5_no_err_yet", 32'(mem_err), 32'd0);
      tick();
    end
    chk("t5_err", 32'(mem_err), 32'd1);
    chk("t5_mw_cnt", 32'(mem_wait_cnt), 32'd19);
    mem_ready = 1'b1;
    #1 chk_ctl("t5_err_frozen", FREEZE);
    tick();
    chk("t5_err_sticky", 32'(mem_err), 32'd1);

    // reset out of ERR
    reset_n = 1'b0;
    ex_branch_taken = 1'b1;
    #1 chk_ctl("t5_rst_ctl", NORM);
    chk("t5_rst_err", 32'(mem_err), 32'd0);
    chk("t5_rst_lu", 32'(lu_stall_cnt), 32'd0);
    chk("t5_rst_mw", 32'(mem_wait_cnt), 32'd0);
    ex_branch_taken = 1'b0;
    #2 reset_n = 1'b1;
    mem_ready = 1'b0;
    #1 chk_ctl("t5_after_rst", NORM);
    tick();

    // reset in the middle of a wait
    mem_ready = 1'b1;
    set_id(1'b1, 5'd0, 5'd0, 5'd9, LW);
    tick();
    set_id(1'b0, 5'd0, 5'd0, 5'd0, 8'd0);
    tick();
    mem_ready = 1'b0;
    #1 chk_ctl("t6_w1", FREEZE);
    tick();
    #1 chk_ctl("t6_w2", FREEZE);
    tick();
    chk("t6_mw_pre", 32'(mem_wait_cnt), 32'd2);
    reset_n = 1'b0;
    #1 chk_ctl("t6_rst_ctl", NORM);
    chk("t6_rst_mw", 32'(mem_wait_cnt), 32'd0);
    #2 reset_n = 1'b1;
    #1 chk_ctl("t6_no_stale", NORM);
    tick();
    #1 chk_ctl("t6_run", NORM);
    chk("t6_mw_post", 32'(mem_wait_cnt), 32'd0);
    chk("t6_err_post", 32'(mem_err), 32'd0);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
